sdram_rd_capture: RTL and testbench

Read-data capture stage for the SDRAM controller. It sits directly downstream of the CAS-latency delay line, which delays the read strobe and tag by the configured latency. The block registers the DQ bus on each delayed strobe and buffers the beats in a small FIFO. It presents the beats to the bus side with a valid/ready handshake and marks the last beat of each burst. It also returns issue credit to the command scheduler so the FIFO can never overflow under legal use.

---
 rtl/sdram_rd_capture.sv | 138 +++++++++++++
 tb/tb_sdram_rd_capture.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sdram_rd_capture.sv
// Read-data capture stage: registers DQ on each delayed read strobe,
// buffers beats in a small FIFO with burst-last marking, and returns
// issue credit to the scheduler so the FIFO cannot overflow.
module sdram_rd_capture #(
  parameter int DW    = 16,
  parameter int TAGW  = 2,
  parameter int AW    = 3,
  parameter int BURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rd_issue,
  input  logic            dly_valid,
  input  logic [TAGW-1:0] dly_tag,
  input  logic [DW-1:0]   dq_in,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [TAGW-1:0] out_tag,
  output logic            out_last,
  input  logic            out_ready,
  output logic            credit_ok,
  output logic            overflow
);

  localparam int DEPTH = 1 << AW;
  localparam int EW    = DW + TAGW + 1;

  typedef logic [AW:0]   cnt_t;
  typedef logic [AW-1:0] ptr_t;
  typedef logic [EW-1:0] entry_t;

  localparam cnt_t          DEPTH_C   = cnt_t'(DEPTH);
  localparam cnt_t          BURST_C   = cnt_t'(BURST);
  localparam ptr_t          BEAT_LAST = ptr_t'(BURST - 1);
  localparam logic [AW+1:0] USED_MAX  = (AW+2)'(DEPTH - BURST);

  // Capture register (stage 1)
  logic            cap_v;
  logic [DW-1:0]   cap_data;
  logic [TAGW-1:0] cap_tag;
  logic            cap_last;
  ptr_t            beat_cnt;

  // FIFO storage and bookkeeping
  entry_t          mem [DEPTH];
  ptr_t            wr_ptr;
  ptr_t            rd_ptr;
  cnt_t            count;
  cnt_t            reserved;
  logic            overflow_r;

  // Combinational control
  logic            full;
  logic            wr_commit;
  logic            wr_drop;
  logic            pop;
  logic            illegal_issue;
  logic            res_underflow;
  logic [AW+1:0]   used;
  cnt_t            count_nxt;
  cnt_t            reserved_nxt;
  entry_t          head;
  entry_t          cap_entry;

  // Stage 1: register DQ/tag on each delayed strobe and track the burst beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_v    <= 1'b0;
      cap_data <= '0;
      cap_tag  <= '0;
      cap_last <= 1'b0;
      beat_cnt <= '0;
    end else begin
      cap_v <= dly_valid;
      if (dly_valid) begin
        cap_data <= dq_in;
        cap_tag  <= dly_tag;
        cap_last <= (beat_cnt == BEAT_LAST);
        beat_cnt <= (beat_cnt == BEAT_LAST) ? '0 : beat_cnt + ptr_t'(1);
      end
    end
  end

  // FIFO control, write/pop qualification, credit and accounting deltas
  always_comb begin
    full          = (count == DEPTH_C);
    wr_commit     = cap_v & ~full;
    wr_drop       = cap_v & full;
    out_valid     = (count != '0);
    pop           = out_valid & out_ready;
    used          = {1'b0, count} + {1'b0, reserved};
    credit_ok     = (used <= USED_MAX);
    illegal_issue = rd_issue & ~credit_ok;
    res_underflow = wr_commit & (reserved == '0);
    count_nxt     = count + cnt_t'(wr_commit) - cnt_t'(pop);
    // reserved saturates at zero on an unexpected beat instead of wrapping
    reserved_nxt  = reserved + (rd_issue ? BURST_C : '0)
                  - cnt_t'(wr_commit & (reserved != '0));
    cap_entry     = {cap_data, cap_tag, cap_last};
  end

  // Stage 2: pointer, occupancy, reservation and sticky violation state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      reserved   <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (wr_commit) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop)       rd_ptr <= rd_ptr + ptr_t'(1);
      count    <= count_nxt;
      reserved <= reserved_nxt;
      if (illegal_issue | wr_drop | res_underflow) overflow_r <= 1'b1;
    end
  end

  // FIFO storage write; contents need no reset since count gates the output
  always_ff @(posedge clk) begin
    if (wr_commit) mem[wr_ptr] <= cap_entry;
  end

  // Head presentation, forced to zero while empty
  always_comb begin
    head     = mem[rd_ptr];
    out_data = '0;
    out_tag  = '0;
    out_last = 1'b0;
    if (out_valid) begin
      out_data = head[EW-1 -: DW];
      out_tag  = head[TAGW:1];
      out_last = head[0];
    end
    overflow = overflow_r;
  end

endmodule

// File: tb/tb_sdram_rd_capture.sv
// Directed, scoreboard-based bench for the read-data capture stage.
module tb_sdram_rd_capture;

  localparam int DW    = 16;
  localparam int TAGW  = 2;
  localparam int AW    = 3;
  localparam int BURST = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            rd_issue = 1'b0;
  logic            dly_valid = 1'b0;
  logic [TAGW-1:0] dly_tag = '0;
  logic [DW-1:0]   dq_in = '0;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [TAGW-1:0] out_tag;
  logic            out_last;
  logic            out_ready = 1'b0;
  logic            credit_ok;
  logic            overflow;

  int unsigned checks = 0;
  int unsigned passed = 0;
  int unsigned tb_beat = 0;
  logic [DW+TAGW:0] q[$];
  logic [DW+TAGW:0] mon_exp;

  sdram_rd_capture #(.DW(DW), .TAGW(TAGW), .AW(AW), .BURST(BURST)) dut (
    .clk(clk), .rst(rst), .rd_issue(rd_issue), .dly_valid(dly_valid),
    .dly_tag(dly_tag), .dq_in(dq_in), .out_valid(out_valid),
    .out_data(out_data), .out_tag(out_tag), .out_last(out_last),
    .out_ready(out_ready), .credit_ok(credit_ok), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [TAGW-1:0] t);
    dly_valid = 1'b1;
    dq_in     = d;
    dly_tag   = t;
    q.push_back({d, t, (tb_beat == BURST - 1)});
    tb_beat = (tb_beat + 1) % BURST;
    tick();
    dly_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int k = 0; k < 60 && (q.size() != 0 || out_valid); k++) tick();
    chk(tag, {30'd0, q.size() == 0, out_valid}, 32'h2);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    q.delete();
    tb_beat = 0;
    repeat (3) tick();
    rst = 1'b1;
  endtask

  // Pops are compared against the scoreboard half a cycle before they take effect
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_beat", 32'h1, 32'h0);
      else begin
        mon_exp = q.pop_front();
        chk("beat", {13'd0, out_data, out_tag, out_last}, {13'd0, mon_exp});
      end
    end
  end

  initial begin
    #1 rst = 1'b0;
    repeat (3) tick();
    chk("rst_outs", {11'd0, out_valid, out_last, out_data, out_tag, credit_ok, overflow},
        {11'd0, 1'b0, 1'b0, 16'h0, 2'b00, 1'b1, 1'b0});
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle", {29'd0, out_valid, credit_ok, overflow}, 32'h2);
    end

    // Single burst: issue in cycle 0, beats in cycles 5..8
    out_ready = 1'b1;
    rd_issue = 1'b1;
    tick();
    rd_issue = 1'b0;
    chk("credit_one_burst", {31'd0, credit_ok}, 32'h1);
    repeat (4) tick();
    send_beat(16'h1111, 2'd2);
    chk("latency_n1", {31'd0, out_valid}, 32'h0);
    send_beat(16'h2222, 2'd2);
    chk("latency_n2", {31'd0, out_valid}, 32'h1);
    send_beat(16'h3333, 2'd2);
    send_beat(16'h4444, 2'd2);
    wait_drain("drain_single");
    chk("single_after", {30'd0, credit_ok, overflow}, 32'h2);

    // Credit exhaustion and full FIFO
    out_ready = 1'b0;
    rd_issue = 1'b1;
    tick();
    chk("credit_after_1", {31'd0, credit_ok}, 32'h1);
    tick();
    rd_issue = 1'b0;
    chk("credit_after_2", {31'd0, credit_ok}, 32'h0);
    for (int i = 0; i < 8; i++) send_beat(16'h5000 + 16'(i), 2'd1);
    repeat (2) tick();
    chk("full_state", {29'd0, out_valid, credit_ok, overflow}, 32'h4);
    out_ready = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0;
    chk("credit_after_pop4", {30'd0, credit_ok, overflow}, 32'h2);
    out_ready = 1'b1;
    wait_drain("drain_full");

    // Continuous stream with a pop every cycle
    for (int i = 0; i < 16; i++) begin
      rd_issue = (i % BURST == 0);
      send_beat(16'h6000 + 16'(i), 2'(i / BURST));
      rd_issue = 1'b0;
      if (i >= 1) chk("stream_valid", {31'd0, out_valid}, 32'h1);
    end
    wait_drain("drain_stream");
    chk("stream_ovf", {31'd0, overflow}, 32'h0);

    // Alternating backpressure across two bursts
    rd_issue = 1'b1;
    repeat (2) tick();
    rd_issue = 1'b0;
    for (int i = 0; i < 8; i++) begin
      out_ready = ~out_ready;
      send_beat(16'h7000 + 16'(i), 2'(i / BURST));
    end
    for (int k = 0; k < 40 && q.size() != 0; k++) begin
      out_ready = ~out_ready;
      tick();
    end
    out_ready = 1'b1;
    wait_drain("drain_toggle");
    chk("toggle_ovf", {30'd0, credit_ok, overflow}, 32'h2);

    // Illegal issue sets a sticky flag
    rd_issue = 1'b1;
    repeat (2) tick();
    chk("no_ovf_legal", {30'd0, credit_ok, overflow}, 32'h0);
    tick();
    rd_issue = 1'b0;
    chk("ovf_illegal", {31'd0, overflow}, 32'h1);
    repeat (3) tick();
    chk("ovf_sticky", {31'd0, overflow}, 32'h1);
    do_reset();
    chk("ovf_cleared", {30'd0, credit_ok, overflow}, 32'h2);

    // Beat arriving with nothing reserved
    send_beat(16'hBEEF, 2'd3);
    chk("ovf_pre_underflow", {31'd0, overflow}, 32'h0);
    tick();
    chk("ovf_underflow", {31'd0, overflow}, 32'h1);
    wait_drain("drain_underflow");

    // Reset in the middle of a burst
    out_ready = 1'b0;
    rd_issue = 1'b1;
    tick();
    rd_issue = 1'b0;
    send_beat(16'h8000, 2'd1);
    send_beat(16'h8001, 2'd1);
    chk("mid_valid", {31'd0, out_valid}, 32'h1);
    #2 rst = 1'b0;
    q.delete();
    tb_beat = 0;
    #1;
    chk("mid_rst_outs", {11'd0, out_valid, out_last, out_data, out_tag, credit_ok, overflow},
        {11'd0, 1'b0, 1'b0, 16'h0, 2'b00, 1'b1, 1'b0});
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk("post_rst_idle", {29'd0, out_valid, credit_ok, overflow}, 32'h2);
    out_ready = 1'b1;
    rd_issue = 1'b1;
    tick();
    rd_issue = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(16'h9000 + 16'(i), 2'd2);
    wait_drain("drain_post_rst");
    chk("final_state", {29'd0, out_valid, credit_ok, overflow}, 32'h2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
